// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and sizing helper shared by the output-port arbiter.
package arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, LOCK_WAIT} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/noc_out_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, searching upward from ptr_i.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] pick_o,
  output logic         any_o
);
  always_comb begin
    logic [W-1:0] j;
    j = '0;
    pick_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        pick_o = '0;
        pick_o[j] = 1'b1;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/noc_out_port_arbiter.sv
// noc_out_port_arbiter: round-robin scheduler moving flits from N_REQ input FIFOs to one output FIFO.
// Define ARB_PKT_LOCK_EN to hold the grant until a tail flit (MSB set) has been written.
module noc_out_port_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int N_REQ    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_empty,
  input  logic [N_REQ*NUM_BITS-1:0] fifo_data,
  output logic [N_REQ-1:0]          rd_en,
  input  logic                      out_full,
  output logic                      out_wr_en,
  output logic [NUM_BITS-1:0]       out_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy
);
  localparam int W = clog2(N_REQ);
  state_t              state_q;
  logic [N_REQ-1:0]    grant_q, pick;
  logic [W-1:0]        rr_q, rr_d, gidx;
  logic [NUM_BITS-1:0] hold_q, hold_d;
  logic                any;
  rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req_i (~req_empty),
    .ptr_i (rr_q),
    .pick_o(pick),
    .any_o (any)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) if (grant_q[i]) gidx = W'(i);
  end
  assign rr_d      = (gidx == W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  assign hold_d    = fifo_data[gidx*NUM_BITS +: NUM_BITS];
  assign rd_en     = (state_q == ISSUE) ? grant_q : '0;
  assign out_wr_en = (state_q == SEND) && !out_full;
  assign out_data  = hold_q;
  assign grant     = grant_q;
  assign busy      = state_q != IDLE;
  // rst_n is an active-high asynchronous reset in this codebase despite its name
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (any) begin
          grant_q <= pick;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          hold_q  <= hold_d;
          state_q <= SEND;
        end
        SEND: if (!out_full) begin
`ifdef ARB_PKT_LOCK_EN
          if (!hold_q[NUM_BITS-1]) state_q <= req_empty[gidx] ? LOCK_WAIT : ISSUE;
          else begin
            rr_q    <= rr_d;
            grant_q <= '0;
            state_q <= IDLE;
          end
`else
          rr_q    <= rr_d;
          grant_q <= '0;
          state_q <= IDLE;
`endif
        end
`ifdef ARB_PKT_LOCK_EN
        LOCK_WAIT: if (!req_empty[gidx]) state_q <= ISSUE;
`endif
        default: state_q <= IDLE;
      endcase
    end
endmodule
